// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch unit: fetch state encoding,
// instruction field widths, the IR reset constant and a helper that packs the
// ROM fields into one instruction word.
// Ports: none (package).
// ---------------------------------------------------------------------------
package fetch_pkg;

    localparam int FORMAT_W  = 1;
    localparam int OPCODE_W  = 4;
    localparam int SIGN_W    = 1;
    localparam int OPERAND_W = 3;
    localparam int INSTR_W   = FORMAT_W + OPCODE_W + SIGN_W + OPERAND_W;

    localparam logic [INSTR_W-1:0] IR_RESET = '0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    // Instruction word layout: {format, opcode, sign, operand}.
    function automatic logic [INSTR_W-1:0] pack_instr(
        input logic [FORMAT_W-1:0]  format,
        input logic [OPCODE_W-1:0]  opcode,
        input logic [SIGN_W-1:0]    sign,
        input logic [OPERAND_W-1:0] operand
    );
        return {format, opcode, sign, operand};
    endfunction

endpackage

// File: rtl/fetch_pc_sel.sv
// ---------------------------------------------------------------------------
// fetch_pc_sel
// Combinational next-PC selection for the fetch unit. Priority, highest first:
// halt (hold), absolute jump, relative branch, out-of-bound (hold), stall
// (hold), sequential increment.
// Ports:
//   run          in  1     unit is in RUN; otherwise the PC is held
//   halt_req     in  1     stop fetching; PC held
//   jmp_valid    in  1     absolute jump request
//   jmp_target   in  PC_W  absolute jump address
//   br_taken     in  1     relative branch request
//   br_offset    in  8     signed branch offset, relative to ir_pc
//   stall        in  1     decode not ready; hold
//   out_of_bound in  1     current PC is outside the program (hold, no load)
//   pc           in  PC_W  current PC
//   ir_pc        in  PC_W  PC of the instruction held in IR
//   next_pc      out PC_W  PC for the next cycle
//   flush        out 1     a redirect was taken; the word fetched now is dropped
//   load         out 1     the ROM word at pc is captured into IR
// ---------------------------------------------------------------------------
module fetch_pc_sel #(
    parameter int PC_W = 16
) (
    input  logic            run,
    input  logic            halt_req,
    input  logic            jmp_valid,
    input  logic [PC_W-1:0] jmp_target,
    input  logic            br_taken,
    input  logic [7:0]      br_offset,
    input  logic            stall,
    input  logic            out_of_bound,
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] ir_pc,
    output logic [PC_W-1:0] next_pc,
    output logic            flush,
    output logic            load
);

    localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

    logic [PC_W-1:0] br_ext;

    // Sign-extend the 8-bit offset; the add below wraps modulo 2^PC_W.
    assign br_ext = {{(PC_W-8){br_offset[7]}}, br_offset};

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        next_pc = pc;
        flush   = 1'b0;
        load    = 1'b0;
        if (run && !halt_req) begin
            if (jmp_valid) begin
                next_pc = jmp_target;
                flush   = 1'b1;
            end else if (br_taken) begin
                next_pc = ir_pc + br_ext;
                flush   = 1'b1;
            end else if (!out_of_bound && !stall) begin
                next_pc = pc + PC_ONE;
                load    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
// Instruction fetch sequencer. Owns the PC, drives it to a combinational ROM
// and registers the returned 9-bit word into IR with its PC. Handles
// sequential increment, relative branch, absolute jump, stall and halt.
// Optional feature: define FETCH_BOUND_CHECK_EN to halt with a sticky fault
// when the PC reaches PROG_LEN; when undefined, fault stays 0 and the PC
// free-runs and wraps.
// Ports:
//   clk         in  1     rising-edge clock
//   reset       in  1     synchronous, active-high
//   pc_out      out PC_W  ROM address (register output)
//   rom_format  in  1     ROM format bit
//   rom_opcode  in  4     ROM opcode field
//   rom_sign    in  1     ROM sign bit
//   rom_operand in  3     ROM operand field
//   stall       in  1     decode not ready; hold PC and IR
//   br_taken    in  1     relative branch request
//   br_offset   in  8     signed branch offset relative to ir_pc
//   jmp_valid   in  1     absolute jump request
//   jmp_target  in  PC_W  absolute jump address
//   halt_req    in  1     stop fetching
//   ir          out 9     registered instruction {format, opcode, sign, operand}
//   ir_pc       out PC_W  PC of the instruction in ir
//   ir_valid    out 1     ir holds a live instruction
//   halted      out 1     unit is in HALTED
//   fault       out 1     PC left program bounds (sticky until reset)
// ---------------------------------------------------------------------------
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              PROG_LEN = 35
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic [PC_W-1:0]      pc_out,
    input  logic                 rom_format,
    input  logic [OPCODE_W-1:0]  rom_opcode,
    input  logic                 rom_sign,
    input  logic [OPERAND_W-1:0] rom_operand,
    input  logic                 stall,
    input  logic                 br_taken,
    input  logic [7:0]           br_offset,
    input  logic                 jmp_valid,
    input  logic [PC_W-1:0]      jmp_target,
    input  logic                 halt_req,
    output logic [INSTR_W-1:0]   ir,
    output logic [PC_W-1:0]      ir_pc,
    output logic                 ir_valid,
    output logic                 halted,
    output logic                 fault
);

`ifdef FETCH_BOUND_CHECK_EN
    localparam bit BOUND_EN = 1'b1;
`else
    localparam bit BOUND_EN = 1'b0;
`endif

    localparam logic [PC_W-1:0] PROG_END = PC_W'(PROG_LEN);

    fetch_state_t        state;
    logic [PC_W-1:0]     pc_q;
    logic [INSTR_W-1:0]  ir_q;
    logic [PC_W-1:0]     ir_pc_q;
    logic                ir_valid_q;
    logic                halted_q;
    logic                fault_q;

    logic [PC_W-1:0]     next_pc;
    logic                flush;
    logic                load;
    logic                out_of_bound;
    logic [INSTR_W-1:0]  rom_word;

    assign rom_word     = pack_instr(rom_format, rom_opcode, rom_sign, rom_operand);
    // Constant-false in the default build, so the fault path folds away.
    assign out_of_bound = BOUND_EN && (pc_q >= PROG_END);

    fetch_pc_sel #(
        .PC_W (PC_W)
    ) u_pc_sel (
        .run          (state == RUN),
        .halt_req     (halt_req),
        .jmp_valid    (jmp_valid),
        .jmp_target   (jmp_target),
        .br_taken     (br_taken),
        .br_offset    (br_offset),
        .stall        (stall),
        .out_of_bound (out_of_bound),
        .pc           (pc_q),
        .ir_pc        (ir_pc_q),
        .next_pc      (next_pc),
        .flush        (flush),
        .load         (load)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pc_q       <= RESET_PC;
            ir_q       <= IR_RESET;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
            halted_q   <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // PC already holds RESET_PC; this cycle only presents it.
                    state <= RUN;
                end
                RUN: begin
                    pc_q <= next_pc;
                    if (halt_req) begin
                        state      <= HALTED;
                        halted_q   <= 1'b1;
                        ir_valid_q <= 1'b0;
                    end else if (flush) begin
                        // Word fetched from the old stream is dropped: one bubble.
                        ir_valid_q <= 1'b0;
                    end else if (out_of_bound) begin
                        state      <= HALTED;
                        halted_q   <= 1'b1;
                        fault_q    <= 1'b1;
                        ir_valid_q <= 1'b0;
                    end else if (load) begin
                        ir_q       <= rom_word;
                        ir_pc_q    <= pc_q;
                        ir_valid_q <= 1'b1;
                    end
                    // Stall: nothing is written, everything holds.
                end
                HALTED: begin
                    // Only reset leaves HALTED.
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign pc_out   = pc_q;
    assign ir       = ir_q;
    assign ir_pc    = ir_pc_q;
    assign ir_valid = ir_valid_q;
    assign halted   = halted_q;
    assign fault    = fault_q;

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch sequencer that drives the program counter into the combinational instruction ROM and registers the returned 9-bit instruction into an instruction register (IR) for decode. It owns the PC and applies sequential increment, relative branches, absolute jumps, stalls and halt. It sits between the instruction ROM (PC out, fields in) and the decode/execute stage (IR out, redirect/stall/halt in).

## Interface
- `PC_W`, 16, PC width; matches ROM address port
- `RESET_PC`, 0, PC value loaded on reset
- `PROG_LEN`, 35, number of valid ROM words; used only with bound checking
- `clk` in 1, rising-edge clock
- `reset` in 1, synchronous, active-high
- `pc_out` out PC_W, address to ROM `pc_in`
- `rom_format` in 1, ROM format bit
- `rom_opcode` in 4, ROM opcode field
- `rom_sign` in 1, ROM sign bit
- `rom_operand` in 3, ROM operand field
- `stall` in 1, decode not ready; hold PC and IR
- `br_taken` in 1, relative branch request from execute
- `br_offset` in 8, signed two's-complement branch offset
- `jmp_valid` in 1, absolute jump request
- `jmp_target` in PC_W, absolute jump address
- `halt_req` in 1, stop fetching
- `ir` out 9, registered instruction {format, opcode, sign, operand}
- `ir_pc` out PC_W, PC of instruction in `ir`
- `ir_valid` out 1, `ir` holds a live instruction
- `halted` out 1, unit is in HALTED
- `fault` out 1, PC left program bounds (see Configuration)

## Operation
- States: IDLE, RUN, HALTED. Reset forces IDLE.
- IDLE: one cycle; `pc_out`=RESET_PC, no IR load; next state RUN.
- RUN, per cycle, priority highest first:
  - `halt_req`: next state HALTED, `ir_valid`<=0, PC held.
  - `jmp_valid`: PC<=`jmp_target`; `ir_valid`<=0 (flush word fetched this cycle).
  - `br_taken`: PC<=`ir_pc` + sign-extend(`br_offset`), modulo 2^PC_W; `ir_valid`<=0.
  - `stall`: PC, `ir`, `ir_pc`, `ir_valid` held.
  - otherwise: `ir`<=ROM word, `ir_pc`<=`pc_out`, `ir_valid`<=1, PC<=PC+1 (wraps 2^PC_W-1 -> 0).
- Redirects override `stall` in the same cycle.
- HALTED: all registers held, `ir_valid`=0, `halted`=1; exit only via `reset`.
- Branch/jump inputs are sampled only in RUN; ignored in IDLE/HALTED.

## Timing
- Reset values: `pc_out`=RESET_PC, `ir`=0, `ir_pc`=0, `ir_valid`=0, `halted`=0, `fault`=0.
- Fetch latency: address on `pc_out` in cycle N appears in `ir` with `ir_valid`=1 in cycle N+1.
- Redirect penalty: exactly one bubble; target instruction valid two cycles after redirect cycle.
- Reset mid-run: next cycle all outputs at reset values, state IDLE; first valid IR three cycles after reset deasserts (IDLE, fetch, IR).
- ROM is combinational; `pc_out` is a register output only.

## Configuration
- `FETCH_BOUND_CHECK_EN` defined: in RUN, if `pc_out` >= PROG_LEN and no redirect/halt this cycle, the word is not loaded, state -> HALTED, `fault`<=1 (sticky until reset).
- Undefined: no bound check, `fault` tied 0, PC free-runs and wraps.

## Structure
- Shared package `fetch_pkg`: state enum (IDLE/RUN/HALTED), field widths (format 1, opcode 4, sign 1, operand 3, instr 9), IR reset constant.
- One sub-module `fetch_pc_sel`: combinational next-PC mux (increment, branch adder with sign extension, jump, hold) plus flush flag.

## Test plan
- Reset, free run, ROM word 0 = 9'b000000001 -> cycle 2 `ir`=9'h001, `ir_pc`=0; `ir_pc` then 1,2,3 on consecutive cycles.
- `br_taken` with `ir_pc`=10, `br_offset`=8'hFC -> one cycle `ir_valid`=0, then `ir_pc`=6.
- `jmp_valid`=1, `jmp_target`=20, `br_taken`=1 and `stall`=1 same cycle -> jump wins, next valid `ir_pc`=20.
- `stall` held 3 cycles at `ir_pc`=5 -> `ir`, `ir_pc`=5, `pc_out`=6 unchanged for 3 cycles, resume with `ir_pc`=6.
- `halt_req` at `pc_out`=12 -> `halted`=1, `ir_valid`=0 held indefinitely; `reset` -> `pc_out`=0, IDLE.
- With `FETCH_BOUND_CHECK_EN`, run to `pc_out`=35 -> `fault`=1, `halted`=1, last valid `ir_pc`=34; without macro, PC=16'hFFFF wraps to 0.
